// File: rtl/rsa_decrypt_ctrl.sv
// ============================================================================
// Module   : rsa_decrypt_ctrl (with RSA_IP key generator)
// Purpose  : Captures one key, buffers 8 ciphertexts, decrypts with a
//            square-and-multiply datapath and streams the plaintexts out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module RSA_IP #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   IN_P,
    input  logic [WIDTH-1:0]   IN_Q,
    input  logic [2*WIDTH-1:0] IN_E,
    output logic [2*WIDTH-1:0] OUT_N,
    output logic [2*WIDTH-1:0] OUT_D
);
    localparam int KW = 2 * WIDTH;
    localparam int PW = 4 * WIDTH;

    logic [KW-1:0] phi;
    logic [PW-1:0] prod;

    // D is the smallest d with E*d == 1 mod phi; 0 when no inverse exists.
    always_comb begin
        OUT_N = KW'(IN_P) * KW'(IN_Q);
        phi   = (KW'(IN_P) - KW'(1)) * (KW'(IN_Q) - KW'(1));
        OUT_D = '0;
        prod  = '0;
        for (int i = (1 << KW) - 1; i >= 1; i--) begin
            prod = PW'(IN_E) * PW'(i);
            if ((phi != '0) && ((prod % PW'(phi)) == PW'(1))) begin
                OUT_D = KW'(i);
            end
        end
    end
endmodule

module rsa_decrypt_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_p,
    input  logic [WIDTH-1:0]   in_q,
    input  logic [2*WIDTH-1:0] in_e,
    input  logic               in_valid2,
    input  logic [2*WIDTH-1:0] in_c,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out_m
);
    localparam int KW = 2 * WIDTH;
    localparam int PW = 4 * WIDTH;
    localparam int CW = $clog2(KW + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_C = 3'd1,
        S_LOAD   = 3'd2,
        S_EXP    = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t          state_q;
    logic [WIDTH-1:0] p_q, q_q;
    logic [KW-1:0]   e_q, n_q, d_q;
    logic [KW-1:0]   c_buf_q [8];
    logic [KW-1:0]   m_buf_q [8];
    logic [2:0]      slot_q, idx_q;
    logic [CW-1:0]   cyc_q;
    logic [KW-1:0]   base_q, res_q, exp_q;
    logic            out_valid_q;
    logic [KW-1:0]   out_m_q;

    logic            key_load_d;
    logic [WIDTH-1:0] ip_p_d, ip_q_d;
    logic [KW-1:0]   ip_e_d, ip_n_d, ip_d_d;
    logic [KW-1:0]   res_mul_d, base_sq_d, res_next_d, c_mod_d, one_mod_d;

    function automatic logic [KW-1:0] mod_n(input logic [PW-1:0] a, input logic [KW-1:0] n);
        logic [PW-1:0] r;
        r = (n == '0) ? a : (a % PW'(n));
        return r[KW-1:0];
    endfunction

    // The IP sees the incoming key in the strobe cycle so N/D register at T+1.
    assign key_load_d = in_valid && ((state_q == S_IDLE) || (state_q == S_WAIT_C));
    assign ip_p_d     = key_load_d ? in_p : p_q;
    assign ip_q_d     = key_load_d ? in_q : q_q;
    assign ip_e_d     = key_load_d ? in_e : e_q;

    RSA_IP #(.WIDTH(WIDTH)) u_rsa_ip (
        .IN_P  (ip_p_d),
        .IN_Q  (ip_q_d),
        .IN_E  (ip_e_d),
        .OUT_N (ip_n_d),
        .OUT_D (ip_d_d)
    );

    assign res_mul_d  = mod_n(PW'(res_q) * PW'(base_q), n_q);
    assign base_sq_d  = mod_n(PW'(base_q) * PW'(base_q), n_q);
    assign res_next_d = exp_q[0] ? res_mul_d : res_q;
    assign c_mod_d    = mod_n(PW'(c_buf_q[idx_q]), n_q);
    assign one_mod_d  = mod_n(PW'(1), n_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            q_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            d_q         <= '0;
            slot_q      <= '0;
            idx_q       <= '0;
            cyc_q       <= '0;
            base_q      <= '0;
            res_q       <= '0;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            out_m_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                c_buf_q[i] <= '0;
                m_buf_q[i] <= '0;
            end
        end else begin
            if (key_load_d) begin
                p_q <= in_p;
                q_q <= in_q;
                e_q <= in_e;
                n_q <= ip_n_d;
                d_q <= ip_d_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (in_valid) state_q <= S_WAIT_C;
                end
                S_WAIT_C: begin
                    if (!in_valid && in_valid2) begin
                        c_buf_q[0] <= in_c;
                        slot_q     <= 3'd1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid2) begin
                        c_buf_q[slot_q] <= in_c;
                        slot_q          <= slot_q + 3'd1;
                        if (slot_q == 3'd7) begin
                            state_q <= S_EXP;
                            idx_q   <= 3'd0;
                            cyc_q   <= '0;
                        end
                    end
                end
                S_EXP: begin
                    if (cyc_q == '0) begin
                        base_q <= c_mod_d;
                        res_q  <= one_mod_d;
                        exp_q  <= d_q;
                        cyc_q  <= CW'(1);
                    end else begin
                        res_q  <= res_next_d;
                        base_q <= base_sq_d;
                        exp_q  <= exp_q >> 1;
                        if (cyc_q == CW'(KW)) begin
                            m_buf_q[idx_q] <= res_next_d;
                            cyc_q          <= '0;
                            idx_q          <= idx_q + 3'd1;
                            if (idx_q == 3'd7) begin
                                state_q     <= S_OUT;
                                slot_q      <= 3'd1;
                                out_valid_q <= 1'b1;
                                out_m_q     <= m_buf_q[0];
                            end
                        end else begin
                            cyc_q <= cyc_q + CW'(1);
                        end
                    end
                end
                S_OUT: begin
                    // slot_q wraps to 0 once slot 7 is on the output.
                    if (slot_q == 3'd0) begin
                        out_valid_q <= 1'b0;
                        out_m_q     <= '0;
                        state_q     <= S_WAIT_C;
                    end else begin
                        out_m_q <= m_buf_q[slot_q];
                        slot_q  <= slot_q + 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_m     = out_m_q;
endmodule

`default_nettype wire
